mux_nx1_reg_hs: RTL and testbench

//   Parametrised N:1 multiplexer for the datapath, WIDTH bits per channel, with a registered output.
//   It carries a valid/ready handshake on every input and on the output, plus a transfer counter.

---
 rtl/mux_nx1_reg_hs_if.sv | 28 ++
 rtl/mux_nx1_reg_hs.sv | 106 ++++++++++
 tb/tb_mux_nx1_reg_hs.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_reg_hs_if.sv
// Handshake bundle for mux_nx1_reg_hs: N input channels, one registered output, status.
// The master modport is the producer/consumer side and the slave modport is the multiplexer.
interface mux_nx1_reg_hs_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
  logic [31:0]        xfer_cnt;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, sel_err, xfer_cnt
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, sel_err, xfer_cnt
  );
endinterface

// File: rtl/mux_nx1_reg_hs.sv
// N:1 registered multiplexer with valid/ready handshake, select-error pulse and transfer counter.
// Define MUX_RR_ARB_EN to replace the external select with a round-robin arbiter.
module mux_nx1_reg_hs #(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input logic             clk,
  input logic             reset_n,
  mux_nx1_reg_hs_if.slave bus
);
  localparam int SEL_W = $clog2(N);

  logic             slot_free;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             accept;
  logic [WIDTH-1:0] grant_data;
  logic [N-1:0]     ready;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [31:0]      cnt_q;

  assign slot_free = ~valid_q | bus.out_ready;

`ifdef MUX_RR_ARB_EN
  logic [SEL_W-1:0] ptr_q;
  logic             unused_sel;

  assign unused_sel = ^bus.sel;

  // Scan from the far end back towards ptr_q so the nearest valid channel wins.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.in_valid[(int'(ptr_q) + k) % N]) begin
        grant    = SEL_W'((int'(ptr_q) + k) % N);
        grant_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= SEL_W'((int'(grant) + 1) % N);
    end
  end

  assign bus.sel_err = 1'b0;
`else
  logic sel_err_q;

  always_comb begin
    grant    = bus.sel;
    grant_ok = (int'(bus.sel) < N);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= ~grant_ok & slot_free;
    end
  end

  assign bus.sel_err = sel_err_q;
`endif

  // Ready depends only on grant and output occupancy, and is forced low in reset.
  always_comb begin
    ready = '0;
    if (reset_n && grant_ok) begin
      ready[grant] = slot_free;
    end
  end

  assign grant_data = bus.in_data[int'(grant) * WIDTH +: WIDTH];
  assign accept     = grant_ok & bus.in_valid[grant] & slot_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= grant_data;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (valid_q && bus.out_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_mux_nx1_reg_hs.sv
// Scoreboard bench for mux_nx1_reg_hs: a driver predicts accepted words into a queue and
// a negedge monitor pops and compares them; a second N=3 instance covers the bad-select case.
module tb_mux_nx1_reg_hs;
  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  mux_nx1_reg_hs_if #(.WIDTH(64), .N(4)) bus4 ();
  mux_nx1_reg_hs_if #(.WIDTH(64), .N(3)) bus3 ();

  mux_nx1_reg_hs #(.WIDTH(64), .N(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  mux_nx1_reg_hs #(.WIDTH(64), .N(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ch[4];
  bit          mdl_full = 1'b0;
  logic [31:0] mdl_cnt = '0;
  int          mdl_ptr = 0;
  logic [63:0] last_word = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules say wins this cycle, or -1 for none.
  function automatic int pickGrant(input logic [3:0] v, input int s, input int ptr);
`ifdef MUX_RR_ARB_EN
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
`else
    return (s < 4) ? s : -1;
`endif
  endfunction

  task automatic applyStimulus(input logic [3:0] v, input int s, input bit ordy);
    int         g;
    bit         slot;
    bit         acc;
    logic [3:0] exp_rdy;
    bus4.in_valid  = v;
    bus4.sel       = 2'(s);
    bus4.out_ready = ordy;
    for (int i = 0; i < 4; i++) bus4.in_data[i*64 +: 64] = ch[i];
    slot    = !mdl_full || ordy;
    g       = pickGrant(v, s, mdl_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = slot;
    acc = (g >= 0) && v[g] && slot;
    #1;
    checkOutput("in_ready", 64'(bus4.in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (mdl_full && ordy) mdl_cnt = mdl_cnt + 32'd1;
    if (acc) begin
      exp_q.push_back(ch[g]);
      mdl_full = 1'b1;
      mdl_ptr  = (g + 1) % 4;
    end else if (ordy) begin
      mdl_full = 1'b0;
    end
    #2;
  endtask

  task automatic doReset();
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b1;
    reset_n        = 1'b0;
    #1;
    checkOutput("rst_out_valid_async", 64'(bus4.out_valid), 64'd0);
    checkOutput("rst_out_data_async", bus4.out_data, 64'd0);
    checkOutput("rst_in_ready", 64'(bus4.in_ready), 64'd0);
    checkOutput("rst_dut3_valid", 64'(bus3.out_valid), 64'd0);
    exp_q.delete();
    mdl_full = 1'b0;
    mdl_cnt  = '0;
    mdl_ptr  = 0;
    bus4.in_valid = 4'h0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("reset_out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("reset_xfer_cnt", 64'(bus4.xfer_cnt), 64'd0);
      checkOutput("reset_sel_err", 64'(bus4.sel_err), 64'd0);
      last_word = '0;
    end else begin
      checkOutput("xfer_cnt", 64'(bus4.xfer_cnt), 64'(mdl_cnt));
      checkOutput("out_valid", 64'(bus4.out_valid), 64'(exp_q.size() != 0));
      checkOutput("sel_err_n4", 64'(bus4.sel_err), 64'd0);
      if (bus4.out_valid && exp_q.size() != 0) begin
        checkOutput("out_data", bus4.out_data, exp_q[0]);
        if (bus4.out_ready) last_word = exp_q.pop_front();
      end else if (!bus4.out_valid) begin
        checkOutput("drained_data", bus4.out_data, last_word);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) ch[i] = '0;
    bus4.in_data = '0; bus4.in_valid = '0; bus4.sel = '0; bus4.out_ready = 1'b1;
    bus3.in_data = '0; bus3.in_valid = '0; bus3.sel = '0; bus3.out_ready = 1'b1;
    @(posedge clk);
    #2;
    doReset();

    ch[0] = 64'd1;
    applyStimulus(4'b0001, 0, 1'b1);
    ch[3] = 64'd2;
    applyStimulus(4'b1000, 3, 1'b1);

    ch[0] = 64'hA5;
    applyStimulus(4'b0001, 0, 1'b0);
    ch[0] = 64'hBB;
    repeat (3) applyStimulus(4'b0001, 0, 1'b0);
    applyStimulus(4'b0001, 0, 1'b1);
    applyStimulus(4'b0000, 0, 1'b1);

    for (int i = 10; i <= 14; i++) begin
      ch[1] = 64'(i);
      applyStimulus(4'b0010, 1, 1'b1);
    end
    applyStimulus(4'b0000, 1, 1'b1);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) ch[i] = {$urandom, $urandom};
      applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    applyStimulus(4'b0000, 0, 1'b1);

    doReset();
    for (int i = 0; i < 4; i++) ch[i] = 64'(i);
    repeat (5) applyStimulus(4'b1111, 0, 1'b1);
    doReset();
    repeat (3) applyStimulus(4'b1010, 1, 1'b1);
    applyStimulus(4'b0000, 0, 1'b1);

    // Counter wrap: preload the count, then complete one transfer.
    force dut4.cnt_q = 32'hFFFF_FFFF;
    mdl_cnt = 32'hFFFF_FFFF;
    #1;
    release dut4.cnt_q;
    applyStimulus(4'b0000, 0, 1'b1);
    ch[2] = 64'h5EED;
    applyStimulus(4'b0100, 2, 1'b1);
    applyStimulus(4'b0000, 2, 1'b1);
    applyStimulus(4'b0000, 2, 1'b1);
    checkOutput("wrap_cnt", 64'(bus4.xfer_cnt), 64'd0);

    ch[0] = 64'hCC;
    applyStimulus(4'b0001, 0, 1'b0);
    applyStimulus(4'b0001, 0, 1'b0);
    doReset();
    applyStimulus(4'b0000, 0, 1'b1);

`ifndef MUX_RR_ARB_EN
    bus3.in_data   = {64'h77, 64'h66, 64'h33};
    bus3.sel       = 2'd3;
    bus3.in_valid  = 3'b111;
    bus3.out_ready = 1'b0;
    #1;
    checkOutput("badsel_in_ready", 64'(bus3.in_ready), 64'd0);
    @(posedge clk); #2;
    checkOutput("badsel_err_1", 64'(bus3.sel_err), 64'd1);
    checkOutput("badsel_valid_1", 64'(bus3.out_valid), 64'd0);
    @(posedge clk); #2;
    checkOutput("badsel_err_2", 64'(bus3.sel_err), 64'd1);
    checkOutput("badsel_valid_2", 64'(bus3.out_valid), 64'd0);
    checkOutput("badsel_in_ready_2", 64'(bus3.in_ready), 64'd0);
    bus3.sel = 2'd0;
    #1;
    checkOutput("goodsel_in_ready", 64'(bus3.in_ready), 64'd1);
    @(posedge clk); #2;
    checkOutput("goodsel_err", 64'(bus3.sel_err), 64'd0);
    checkOutput("goodsel_valid", 64'(bus3.out_valid), 64'd1);
    checkOutput("goodsel_data", bus3.out_data, 64'h33);
    bus3.sel = 2'd3;
    @(posedge clk); #2;
    checkOutput("badsel_full_err", 64'(bus3.sel_err), 64'd0);
    checkOutput("badsel_full_valid", 64'(bus3.out_valid), 64'd1);
    checkOutput("badsel_full_data", bus3.out_data, 64'h33);
`endif

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
